// File: rtl/joy_pkg.sv
// Shared types and constants for the 74HC165 joystick chain reader.
// Bit positions index the active-high joy1/joy2 words.
package joy_pkg;

  localparam int JOY_BITS  = 24;
  localparam int JOY_WIDTH = 12;
  localparam int TICK_W    = 8;

  localparam int BTN_UP    = 11;
  localparam int BTN_DOWN  = 10;
  localparam int BTN_LEFT  = 9;
  localparam int BTN_RIGHT = 8;
  localparam int BTN_FIRE1 = 7;
  localparam int BTN_FIRE2 = 6;
  localparam int BTN_FIRE3 = 5;
  localparam int BTN_FIRE4 = 4;
  localparam int BTN_FIRE5 = 3;
  localparam int BTN_FIRE6 = 2;
  localparam int BTN_FIRE7 = 1;
  localparam int BTN_FIRE8 = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_PUBLISH,
    ST_GAP
  } joy_state_e;

  // The first bit shifted out is the MSB button; the chain is active-low.
  function automatic logic [JOY_WIDTH-1:0] to_buttons(input logic [JOY_WIDTH-1:0] raw);
    logic [JOY_WIDTH-1:0] b;
    b = '0;
    for (int k = 0; k < JOY_WIDTH; k++) b[JOY_WIDTH-1-k] = ~raw[k];
    return b;
  endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV cycles, held at zero while restart is high.
module joy_tick_gen
  import joy_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(CLK_DIV - 1);

  logic [TICK_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (restart || count_q == LAST) count_d = '0;
  end

  assign tick = (count_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/joy_shift_reader.sv
// Reads two 12-button joysticks from a 24-bit 74HC165 chain and publishes
// both words atomically with a one-cycle frame_valid strobe.
module joy_shift_reader
  import joy_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int GAP_TICKS = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic                 enable,
  input  logic                 JOY_DATA,
  output logic                 JOY_CLK,
  output logic                 JOY_LOAD_N,
  output logic [JOY_WIDTH-1:0] joy1,
  output logic [JOY_WIDTH-1:0] joy2,
  output logic                 frame_valid
);

  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int IDX_W = $clog2(JOY_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(JOY_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

  joy_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [JOY_BITS-1:0]  bits_q, bits_d;
  logic [1:0]           sync_q, sync_d;
  logic                 clk_q, clk_d;
  logic                 load_n_q, load_n_d;
  logic                 fv_q, fv_d;
  logic [JOY_WIDTH-1:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic                 tick, restart;

  // Zeroing the prescaler in IDLE and PUBLISH aligns every LOAD and GAP to a full tick.
  assign restart = (state_q == ST_IDLE) || (state_q == ST_PUBLISH);

  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (CLOCK_50),
    .rst     (RESET),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      bits_q   <= '0;
      sync_q   <= 2'b11;
      clk_q    <= 1'b0;
      load_n_q <= 1'b1;
      fv_q     <= 1'b0;
      joy1_q   <= '0;
      joy2_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      bits_q   <= bits_d;
      sync_q   <= sync_d;
      clk_q    <= clk_d;
      load_n_q <= load_n_d;
      fv_q     <= fv_d;
      joy1_q   <= joy1_d;
      joy2_q   <= joy2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    bits_d  = bits_q;
    sync_d  = {sync_q[0], JOY_DATA};
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_LOAD;
      ST_LOAD: begin
        if (tick) begin
          state_d = ST_SHIFT_LO;
          idx_d   = '0;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          bits_d[idx_q] = sync_q[1];
          state_d       = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          if (idx_q == IDX_LAST) state_d = ST_PUBLISH;
          else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_PUBLISH: begin
        gap_d = '0;
        if (GAP_TICKS == 0) state_d = enable ? ST_LOAD : ST_IDLE;
        else                state_d = ST_GAP;
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) state_d = enable ? ST_LOAD : ST_IDLE;
          else                   gap_d   = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins flip on the same edge as the state.
  always_comb begin
    clk_d    = (state_d == ST_SHIFT_HI);
    load_n_d = (state_d != ST_LOAD);
    fv_d     = (state_d == ST_PUBLISH);
    joy1_d   = joy1_q;
    joy2_d   = joy2_q;
    if (state_d == ST_PUBLISH) begin
      joy1_d = to_buttons(bits_q[JOY_WIDTH-1:0]);
      joy2_d = to_buttons(bits_q[JOY_BITS-1:JOY_WIDTH]);
    end
  end

  assign JOY_CLK     = clk_q;
  assign JOY_LOAD_N  = load_n_q;
  assign frame_valid = fv_q;
  assign joy1        = joy1_q;
  assign joy2        = joy2_q;

endmodule

// File: tb/tb_joy_shift_reader.sv
// Bench for joy_shift_reader: instance 0 runs CLK_DIV=8/GAP_TICKS=16, instance 1
// runs CLK_DIV=4/GAP_TICKS=0, each against a behavioural 74HC165 chain.
module tb_joy_shift_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic [1:0]  jdata, jclk, jload_n, fv;
  logic [11:0] joy1_o [2];
  logic [11:0] joy2_o [2];
  logic [11:0] pat1 [2];
  logic [11:0] pat2 [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  joy_shift_reader #(.CLK_DIV(8), .GAP_TICKS(16)) dut_a (
    .CLOCK_50(clk), .RESET(rst), .enable(en[0]), .JOY_DATA(jdata[0]),
    .JOY_CLK(jclk[0]), .JOY_LOAD_N(jload_n[0]),
    .joy1(joy1_o[0]), .joy2(joy2_o[0]), .frame_valid(fv[0])
  );

  joy_shift_reader #(.CLK_DIV(4), .GAP_TICKS(0)) dut_b (
    .CLOCK_50(clk), .RESET(rst), .enable(en[1]), .JOY_DATA(jdata[1]),
    .JOY_CLK(jclk[1]), .JOY_LOAD_N(jload_n[1]),
    .joy1(joy1_o[1]), .joy2(joy2_o[1]), .frame_valid(fv[1])
  );

  // Chain contents in shift order, active-low: joystick 1 MSB first, then joystick 2.
  function automatic logic [23:0] mk_chain(input logic [11:0] p1, input logic [11:0] p2);
    logic [23:0] c;
    for (int k = 0; k < 12; k++) begin
      c[k]      = ~p1[11-k];
      c[12 + k] = ~p2[11-k];
    end
    return c;
  endfunction

  // Chain model: parallel load while LOAD_N low; serial output moves one
  // CLOCK_50 cycle after each JOY_CLK rise.
  logic [23:0] chain [2];
  int          pos [2];
  logic [1:0]  chain_clk_prev = 2'b00;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chain_clk_prev[i] <= jclk[i];
      if (!jload_n[i]) begin
        chain[i] <= mk_chain(pat1[i], pat2[i]);
        pos[i]   <= 0;
      end else if (jclk[i] && !chain_clk_prev[i]) begin
        pos[i] <= pos[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) jdata[i] = (pos[i] < 24) ? chain[i][pos[i]] : 1'b1;
  end

  // Monitor: load pulse width, shift-clock rises per frame, and the scoreboard
  // entry (the pattern latched by each completed load).
  logic [23:0] exp_q_a[$];
  logic [23:0] exp_q_b[$];
  logic [1:0]  mon_load_prev = 2'b11;
  logic [1:0]  mon_clk_prev  = 2'b00;
  int          low_run [2]     = '{0, 0};
  int          last_low [2]    = '{0, 0};
  int          rises [2]       = '{0, 0};
  int          load_pulses [2] = '{0, 0};
  int          fv_count [2]    = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mon_load_prev[i] <= jload_n[i];
      mon_clk_prev[i]  <= jclk[i];
      if (!jload_n[i]) begin
        low_run[i] <= low_run[i] + 1;
      end else if (!mon_load_prev[i]) begin
        last_low[i]    <= low_run[i];
        low_run[i]     <= 0;
        rises[i]       <= 0;
        load_pulses[i] <= load_pulses[i] + 1;
        if (i == 0) exp_q_a.push_back({pat1[i], pat2[i]});
        else        exp_q_b.push_back({pat1[i], pat2[i]});
      end
      if (jclk[i] && !mon_clk_prev[i]) rises[i] <= rises[i] + 1;
      if (fv[i]) fv_count[i] <= fv_count[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input int i, input int max, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < max && !seen) begin
      @(negedge clk);
      n++;
      if (fv[i]) seen = 1'b1;
    end
  endtask

  task automatic wait_rises(input int i, input int target, input int max, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      @(negedge clk);
      n++;
      if (rises[i] == target && jload_n[i]) ok = 1'b1;
    end
  endtask

  task automatic sb_compare(input int i, input string tag);
    logic [23:0] e;
    bit          have;
    have = (i == 0) ? (exp_q_a.size() > 0) : (exp_q_b.size() > 0);
    check({tag, "_sb_entry"}, 32'(have), 32'd1);
    if (have) begin
      if (i == 0) e = exp_q_a.pop_front();
      else        e = exp_q_b.pop_front();
      check({tag, "_joy1"}, 32'(joy1_o[i]), 32'(e[23:12]));
      check({tag, "_joy2"}, 32'(joy2_o[i]), 32'(e[11:0]));
    end
  endtask

  initial begin
    int n, t_last, snap_lp, snap_fv;
    bit seen, ok;

    rst  = 1'b1;
    en   = 2'b00;
    pat1 = '{12'hA5A, 12'h000};
    pat2 = '{12'h3C3, 12'h000};
    repeat (3) @(negedge clk);
    check("rst_joy1", 32'(joy1_o[0]), 32'h0);
    check("rst_joy2", 32'(joy2_o[0]), 32'h0);
    check("rst_fv", 32'(fv[0]), 32'h0);
    check("rst_load_n", 32'(jload_n[0]), 32'h1);
    check("rst_jclk", 32'(jclk[0]), 32'h0);
    rst = 1'b0;
    exp_q_a.delete();
    exp_q_b.delete();

    // First frame: 1 load tick + 48 shift ticks after the edge that samples enable.
    @(negedge clk);
    en[0] = 1'b1;
    wait_frame(0, 1000, n, seen);
    check("f1_seen", 32'(seen), 32'd1);
    check("f1_latency", 32'(n - 1), 32'd392);
    check("f1_joy1", 32'(joy1_o[0]), 32'hA5A);
    check("f1_joy2", 32'(joy2_o[0]), 32'h3C3);
    check("f1_rises", 32'(rises[0]), 32'd24);
    check("f1_load_low", 32'(last_low[0]), 32'd8);
    sb_compare(0, "f1");
    t_last = cyc;
    @(negedge clk);
    check("f1_fv_single", 32'(fv[0]), 32'h0);

    // Change the chain pattern in the middle of the next frame.
    repeat (300) @(negedge clk);
    pat1[0] = 12'hFFF;
    pat2[0] = 12'h000;
    check("f2_mid_joy1_held", 32'(joy1_o[0]), 32'hA5A);
    check("f2_mid_joy2_held", 32'(joy2_o[0]), 32'h3C3);
    wait_frame(0, 1000, n, seen);
    check("f2_seen", 32'(seen), 32'd1);
    check("f2_period", 32'(cyc - t_last), 32'd521);
    check("f2_joy1_old", 32'(joy1_o[0]), 32'hA5A);
    check("f2_joy2_old", 32'(joy2_o[0]), 32'h3C3);
    sb_compare(0, "f2");
    t_last = cyc;
    wait_frame(0, 1000, n, seen);
    check("f3_seen", 32'(seen), 32'd1);
    check("f3_joy1_new", 32'(joy1_o[0]), 32'hFFF);
    check("f3_joy2_new", 32'(joy2_o[0]), 32'h000);
    sb_compare(0, "f3");
    t_last = cyc;

    // Random patterns loaded during the gap.
    for (int f = 0; f < 4; f++) begin
      pat1[0] = 12'($urandom_range(0, 4095));
      pat2[0] = 12'($urandom_range(0, 4095));
      wait_frame(0, 1000, n, seen);
      check("rnd_seen", 32'(seen), 32'd1);
      check("rnd_period", 32'(cyc - t_last), 32'd521);
      check("rnd_rises", 32'(rises[0]), 32'd24);
      sb_compare(0, "rnd");
      t_last = cyc;
    end

    // Drop enable at shift bit 5: frame completes, then no further loads.
    pat1[0] = 12'($urandom_range(0, 4095));
    pat2[0] = 12'($urandom_range(0, 4095));
    wait_rises(0, 5, 1000, ok);
    check("drop_reach_bit5", 32'(ok), 32'd1);
    en[0] = 1'b0;
    wait_frame(0, 1000, n, seen);
    check("drop_seen", 32'(seen), 32'd1);
    sb_compare(0, "drop");
    @(negedge clk);
    snap_lp = load_pulses[0];
    snap_fv = fv_count[0];
    repeat (1200) @(negedge clk);
    check("drop_no_loads", 32'(load_pulses[0] - snap_lp), 32'd0);
    check("drop_no_frames", 32'(fv_count[0] - snap_fv), 32'd0);
    check("drop_load_n_idle", 32'(jload_n[0]), 32'h1);

    // Reset at shift bit 10 discards the partial frame.
    pat1[0] = 12'($urandom_range(0, 4095));
    pat2[0] = 12'($urandom_range(0, 4095));
    en[0] = 1'b1;
    wait_rises(0, 10, 1000, ok);
    check("rst_reach_bit10", 32'(ok), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_joy1", 32'(joy1_o[0]), 32'h0);
    check("midrst_joy2", 32'(joy2_o[0]), 32'h0);
    check("midrst_load_n", 32'(jload_n[0]), 32'h1);
    check("midrst_jclk", 32'(jclk[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q_a.delete();
    snap_lp = load_pulses[0];
    wait_frame(0, 1000, n, seen);
    check("postrst_seen", 32'(seen), 32'd1);
    check("postrst_latency", 32'(n - 1), 32'd392);
    check("postrst_one_load", 32'(load_pulses[0] - snap_lp), 32'd1);
    check("postrst_joy1", 32'(joy1_o[0]), 32'(pat1[0]));
    check("postrst_joy2", 32'(joy2_o[0]), 32'(pat2[0]));
    sb_compare(0, "postrst");
    en[0] = 1'b0;

    // Fast divider, no gap: data moves one cycle after each shift-clock rise.
    pat1[1] = 12'($urandom_range(0, 4095));
    pat2[1] = 12'($urandom_range(0, 4095));
    @(negedge clk);
    en[1] = 1'b1;
    wait_frame(1, 600, n, seen);
    check("b_f1_seen", 32'(seen), 32'd1);
    check("b_f1_latency", 32'(n - 1), 32'd196);
    check("b_f1_rises", 32'(rises[1]), 32'd24);
    check("b_f1_load_low", 32'(last_low[1]), 32'd4);
    sb_compare(1, "b_f1");
    t_last = cyc;
    for (int f = 0; f < 3; f++) begin
      pat1[1] = 12'($urandom_range(0, 4095));
      pat2[1] = 12'($urandom_range(0, 4095));
      wait_frame(1, 600, n, seen);
      check("b_rnd_seen", 32'(seen), 32'd1);
      check("b_rnd_period", 32'(cyc - t_last), 32'd197);
      check("b_rnd_joy1", 32'(joy1_o[1]), 32'(pat1[1]));
      check("b_rnd_joy2", 32'(joy2_o[1]), 32'(pat2[1]));
      sb_compare(1, "b_rnd");
      t_last = cyc;
    end
    en[1] = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/joy_shift_reader.md
JOY_SHIFT_READER -- requirements
Module: joy_shift_reader

Interface
REQ-001 Parameter CLK_DIV, default 8: CLOCK_50 cycles per tick; legal values are 4..255.
REQ-002 Parameter GAP_TICKS, default 16: ticks between the end of one frame and the next load.
REQ-003 Port CLOCK_50, input, 1: the only clock; all logic is on the rising edge.
REQ-004 Port RESET, input, 1: asynchronous, active-high reset.
REQ-005 Port enable, input, 1: when high, frames run continuously.
REQ-006 Port JOY_DATA, input, 1: serial data from the external 74HC165 chain, active-low buttons, asynchronous to CLOCK_50.
REQ-007 Port JOY_CLK, output, 1: shift clock to the chain.
REQ-008 Port JOY_LOAD_N, output, 1: parallel-load strobe to the chain, active-low.
REQ-009 Port joy1, output, 12: joystick 1 buttons, active-high, registered.
REQ-010 Port joy2, output, 12: joystick 2 buttons, active-high, registered.
REQ-011 Port frame_valid, output, 1: single-cycle pulse when joy1 and joy2 update.

Function
REQ-012 A prescaler shall emit one tick every CLK_DIV cycles and shall restart at zero whenever the FSM leaves IDLE.
REQ-013 FSM states shall be IDLE, LOAD, SHIFT_LO, SHIFT_HI, PUBLISH and GAP.
REQ-014 IDLE: JOY_LOAD_N=1, JOY_CLK=0; go to LOAD on the first cycle with enable=1.
REQ-015 LOAD: JOY_LOAD_N=0, JOY_CLK=0 for exactly 1 tick; then go to SHIFT_LO with bit index 0.
REQ-016 SHIFT_LO: JOY_CLK=0 for 1 tick; on the last cycle of the tick, sample the synchronized JOY_DATA into bit[index]; then go to SHIFT_HI.
REQ-017 SHIFT_HI: JOY_CLK=1 for 1 tick; if index=23, go to PUBLISH; otherwise increment index and go to SHIFT_LO.
REQ-018 A frame shall be 1 load tick plus 48 shift ticks; the total from leaving IDLE/GAP to PUBLISH is 49*CLK_DIV cycles.
REQ-019 PUBLISH lasts 1 cycle and sets joy1[11-k]=~bit[k] for k=0..11.
REQ-020 PUBLISH sets joy2[11-k]=~bit[12+k] for k=0..11.
REQ-021 PUBLISH asserts frame_valid for that single cycle.
REQ-022 After PUBLISH the FSM enters GAP, holding JOY_LOAD_N=1 and JOY_CLK=0 for GAP_TICKS ticks.
REQ-023 At the end of GAP: go to LOAD if enable=1, else go to IDLE.
REQ-024 If GAP_TICKS=0, PUBLISH goes straight to LOAD or IDLE.
REQ-025 Dropping enable mid-frame shall not abort the frame; the frame completes, publishes, and stops after GAP.
REQ-026 JOY_DATA shall pass through a 2-flop synchronizer before sampling; CLK_DIV>=4 guarantees 2+ cycles of settling after each JOY_CLK or JOY_LOAD_N edge.
REQ-027 joy1/joy2 shall change only in PUBLISH; a partial frame is never visible.
REQ-028 JOY_CLK and JOY_LOAD_N shall be driven directly from flops, with no combinational glitches.

Reset
REQ-029 RESET=1 shall immediately force: state=IDLE, JOY_CLK=0, JOY_LOAD_N=1, joy1=0, joy2=0, frame_valid=0, prescaler=0, index=0, synchronizer=1.
REQ-030 RESET asserted mid-frame shall discard all collected bits; after release, the first frame starts with a fresh LOAD.

Structure
REQ-031 A shared package joy_pkg shall hold the state enum, the JOY_BITS=24 and JOY_WIDTH=12 constants, and the button bit positions (up, down, left, right, fire1..fire8).
REQ-032 A single sub-module, joy_tick_gen, shall implement the prescaler with a restart input; everything else is in joy_shift_reader.

Verification
REQ-033 Chain model loaded with joy1 pattern 0xA5A, joy2 pattern 0x3C3 (active-high meaning, driven inverted), CLK_DIV=8 -> frame_valid 392 cycles after enable rises, then joy1=0xA5A and joy2=0x3C3.
REQ-034 Count JOY_CLK rising edges between JOY_LOAD_N rising and frame_valid -> exactly 24; JOY_LOAD_N low for exactly 8 cycles.
REQ-035 Chain model changes its pattern to 0xFFF/0x000 mid-frame -> outputs keep the old value until the next PUBLISH, then take only the next full frame's value.
REQ-036 RESET pulsed at shift bit 10 -> outputs 0 at once, JOY_LOAD_N=1, and the next frame starts with LOAD and publishes the correct value.
REQ-037 enable dropped at bit 5, with GAP_TICKS=16 -> frame completes, frame_valid pulses once, then IDLE with no further JOY_LOAD_N pulses.
REQ-038 CLK_DIV=4 with JOY_DATA toggling 1 cycle after each JOY_CLK rise -> all 24 bits are captured correctly.
